// File: rtl/nn_addr_pkg.sv
// Shared definitions for the NN layer address sequencer.
package nn_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_W_BASE = 0;
  localparam int unsigned DEF_BANK0  = 'h00;
  localparam int unsigned DEF_BANK1  = 'h80;

endpackage

// File: rtl/nn_wrap_counter.sv
// Up-counter with enable, synchronous clear and wrap at a programmable terminal count.
module nn_wrap_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q;

  // Wrap fires on the enabled cycle that sits at the terminal count.
  assign wrap_o  = en_i && (count_q == term_i);
  assign count_o = count_q;

  // Count register: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= wrap_o ? '0 : count_q + W'(1);
    end
  end

endmodule

// File: rtl/layer_address_sequencer.sv
// Address sequencer for one fully-connected layer: walks i over inputs for each output j.
module layer_address_sequencer
  import nn_addr_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned NW       = 8,
  parameter int unsigned W_BASE   = DEF_W_BASE,
  parameter int unsigned BANK0    = DEF_BANK0,
  parameter int unsigned BANK1    = DEF_BANK1,
  parameter bit          PINGPONG = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] n_in,
  input  logic [NW-1:0] n_out,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          addr_valid,
  output logic          acc_clear,
  output logic          acc_last,
  output logic          bank,
  output logic [AW-1:0] weight_addr,
  output logic [AW-1:0] neuro_read_addr,
  output logic [AW-1:0] neuro_write_addr
);

  localparam logic [AW-1:0] W_BASE_A = AW'(W_BASE);
  localparam logic [AW-1:0] BANK0_A  = AW'(BANK0);
  localparam logic [AW-1:0] BANK1_A  = AW'(BANK1);

  state_e        state_q;
  logic [NW-1:0] n_in_q;
  logic [NW-1:0] n_out_q;
  logic [AW-1:0] w_q;
  logic          bank_q;

  logic [NW-1:0] i_cnt;
  logic [NW-1:0] j_cnt;
  logic          i_wrap;
  logic          j_wrap;
  logic          advance;
  logic          start_run;
  logic          layer_nonempty;

  assign advance        = (state_q == ST_RUN) && !stall;
  assign start_run      = (state_q == ST_IDLE) && start && (n_in != '0) && (n_out != '0);
  assign layer_nonempty = (n_in_q != '0) && (n_out_q != '0);

  // Input-neuron counter; its wrap steps the output-neuron counter.
  nn_wrap_counter #(.W(NW)) u_i_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (advance),
    .clr_i   (start_run),
    .term_i  (n_in_q - NW'(1)),
    .count_o (i_cnt),
    .wrap_o  (i_wrap)
  );

  // Output-neuron counter; its wrap marks the final beat of the layer.
  nn_wrap_counter #(.W(NW)) u_j_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (i_wrap),
    .clr_i   (start_run),
    .term_i  (n_out_q - NW'(1)),
    .count_o (j_cnt),
    .wrap_o  (j_wrap)
  );

  // Layer FSM with size latches, weight index and bank select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      n_in_q  <= '0;
      n_out_q <= '0;
      w_q     <= '0;
      bank_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            n_in_q  <= n_in;
            n_out_q <= n_out;
            if (start_run) begin
              w_q     <= '0;
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (advance) begin
            w_q <= w_q + AW'(1);
          end
          if (j_wrap) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (PINGPONG && layer_nonempty) begin
            bank_q <= ~bank_q;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes from registered state; addresses from registered counters and bank.
  assign busy             = (state_q == ST_RUN);
  assign done             = (state_q == ST_DONE);
  assign addr_valid       = advance;
  assign acc_clear        = advance && (i_cnt == '0);
  assign acc_last         = i_wrap;
  assign bank             = bank_q;
  assign weight_addr      = W_BASE_A + w_q;
  assign neuro_read_addr  = (bank_q ? BANK1_A : BANK0_A) + AW'(i_cnt);
  assign neuro_write_addr = (bank_q ? BANK0_A : BANK1_A) + AW'(j_cnt);

endmodule

// File: tb/tb_layer_address_sequencer.sv
// Directed vector bench for layer_address_sequencer (AW=NW=8, default bases, ping-pong on).
module tb_layer_address_sequencer;

  typedef struct packed {
    logic       valid;
    logic       clear;
    logic       last;
    logic       busy;
    logic       done;
    logic       bank;
    logic [7:0] rd;
    logic [7:0] wr;
    logic [7:0] wt;
  } out_t;

  typedef struct packed {
    logic       start;
    logic [7:0] n_in;
    logic [7:0] n_out;
    logic       stall;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] n_in;
  logic [7:0] n_out;
  logic       stall;
  logic       busy, done, addr_valid, acc_clear, acc_last, bank;
  logic [7:0] weight_addr, neuro_read_addr, neuro_write_addr;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tab_a[$];
  vec_t tab_b[$];

  always #5 clk = ~clk;

  layer_address_sequencer #(
    .AW(8), .NW(8), .W_BASE(0), .BANK0('h00), .BANK1('h80), .PINGPONG(1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .n_in             (n_in),
    .n_out            (n_out),
    .stall            (stall),
    .busy             (busy),
    .done             (done),
    .addr_valid       (addr_valid),
    .acc_clear        (acc_clear),
    .acc_last         (acc_last),
    .bank             (bank),
    .weight_addr      (weight_addr),
    .neuro_read_addr  (neuro_read_addr),
    .neuro_write_addr (neuro_write_addr)
  );

  function automatic out_t sample();
    out_t o;
    o.valid = addr_valid;
    o.clear = acc_clear;
    o.last  = acc_last;
    o.busy  = busy;
    o.done  = done;
    o.bank  = bank;
    o.rd    = neuro_read_addr;
    o.wr    = neuro_write_addr;
    o.wt    = weight_addr;
    return o;
  endfunction

  function automatic out_t mk(input logic v, input logic c, input logic l, input logic b,
                              input logic d, input logic bk, input int rd, input int wr,
                              input int wt);
    out_t o;
    o.valid = v; o.clear = c; o.last = l; o.busy = b; o.done = d; o.bank = bk;
    o.rd = 8'(rd); o.wr = 8'(wr); o.wt = 8'(wt);
    return o;
  endfunction

  function automatic vec_t mv(input logic st, input int ni, input int no, input logic sl,
                              input out_t e);
    vec_t x;
    x.start = st; x.n_in = 8'(ni); x.n_out = 8'(no); x.stall = sl; x.exp = e;
    return x;
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b clr=%b last=%b busy=%b done=%b bank=%b rd=%h wr=%h wt=%h ; expected v=%b clr=%b last=%b busy=%b done=%b bank=%b rd=%h wr=%h wt=%h",
               nm, act.valid, act.clear, act.last, act.busy, act.done, act.bank, act.rd, act.wr, act.wt,
               exp.valid, exp.clear, exp.last, exp.busy, exp.done, exp.bank, exp.rd, exp.wr, exp.wt);
    end
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic run_table(input string tag, input vec_t tab[$]);
    foreach (tab[k]) begin
      @(negedge clk);
      start = tab[k].start;
      n_in  = tab[k].n_in;
      n_out = tab[k].n_out;
      stall = tab[k].stall;
      #1;
      check($sformatf("%s[%0d]", tag, k), sample(), tab[k].exp);
    end
    @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    n_in  = '0;
    n_out = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_state", sample(), mk(0,0,0,0,0,0, 'h00,'h80,0));

    // Test 1: 3x2 layer on bank 0; sizes driven to 0 mid-run must be ignored.
    tab_a.push_back(mv(1,3,2,0, mk(0,0,0,0,0,0, 'h00,'h80,0)));
    tab_a.push_back(mv(0,0,0,0, mk(1,1,0,1,0,0, 'h00,'h80,0)));
    tab_a.push_back(mv(0,0,0,0, mk(1,0,0,1,0,0, 'h01,'h80,1)));
    tab_a.push_back(mv(0,0,0,0, mk(1,0,1,1,0,0, 'h02,'h80,2)));
    tab_a.push_back(mv(0,0,0,0, mk(1,1,0,1,0,0, 'h00,'h81,3)));
    tab_a.push_back(mv(0,0,0,0, mk(1,0,0,1,0,0, 'h01,'h81,4)));
    tab_a.push_back(mv(0,0,0,0, mk(1,0,1,1,0,0, 'h02,'h81,5)));
    tab_a.push_back(mv(0,0,0,0, mk(0,0,0,0,1,0, 'h00,'h80,6)));
    // Test 2: same sizes on swapped banks.
    tab_a.push_back(mv(1,3,2,0, mk(0,0,0,0,0,1, 'h80,'h00,6)));
    tab_a.push_back(mv(0,3,2,0, mk(1,1,0,1,0,1, 'h80,'h00,0)));
    tab_a.push_back(mv(0,3,2,0, mk(1,0,0,1,0,1, 'h81,'h00,1)));
    tab_a.push_back(mv(0,3,2,0, mk(1,0,1,1,0,1, 'h82,'h00,2)));
    tab_a.push_back(mv(0,3,2,0, mk(1,1,0,1,0,1, 'h80,'h01,3)));
    tab_a.push_back(mv(0,3,2,0, mk(1,0,0,1,0,1, 'h81,'h01,4)));
    tab_a.push_back(mv(0,3,2,0, mk(1,0,1,1,0,1, 'h82,'h01,5)));
    tab_a.push_back(mv(0,3,2,0, mk(0,0,0,0,1,1, 'h80,'h00,6)));
    // Test 3: 2x2 with stall on the 2nd and 3rd run cycles.
    tab_a.push_back(mv(1,2,2,0, mk(0,0,0,0,0,0, 'h00,'h80,6)));
    tab_a.push_back(mv(0,2,2,0, mk(1,1,0,1,0,0, 'h00,'h80,0)));
    tab_a.push_back(mv(0,2,2,1, mk(0,0,0,1,0,0, 'h01,'h80,1)));
    tab_a.push_back(mv(0,2,2,1, mk(0,0,0,1,0,0, 'h01,'h80,1)));
    tab_a.push_back(mv(0,2,2,0, mk(1,0,1,1,0,0, 'h01,'h80,1)));
    tab_a.push_back(mv(0,2,2,0, mk(1,1,0,1,0,0, 'h00,'h81,2)));
    tab_a.push_back(mv(0,2,2,0, mk(1,0,1,1,0,0, 'h01,'h81,3)));
    tab_a.push_back(mv(0,2,2,0, mk(0,0,0,0,1,0, 'h00,'h80,4)));
    // Test 4: empty layer -> immediate done, bank unchanged.
    tab_a.push_back(mv(1,0,5,0, mk(0,0,0,0,0,1, 'h80,'h00,4)));
    tab_a.push_back(mv(0,0,5,0, mk(0,0,0,0,1,1, 'h80,'h00,4)));
    tab_a.push_back(mv(0,0,5,0, mk(0,0,0,0,0,1, 'h80,'h00,4)));
    tab_a.push_back(mv(0,0,5,0, mk(0,0,0,0,0,1, 'h80,'h00,4)));
    run_table("tabA", tab_a);

    // Test 5: reset on the 3rd beat of a 4x4 run (bank 1 beforehand).
    begin
      logic seen_done;
      logic got_done;
      @(negedge clk);
      start = 1'b1; n_in = 8'd4; n_out = 8'd4;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("rst_run_beat0", sample(), mk(1,1,0,1,0,1, 'h80,'h00,0));
      @(negedge clk);
      #1;
      check("rst_run_beat1", sample(), mk(1,0,0,1,0,1, 'h81,'h00,1));
      @(negedge clk);
      #1;
      check("rst_run_beat2", sample(), mk(1,0,0,1,0,1, 'h82,'h00,2));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_midrun_state", sample(), mk(0,0,0,0,0,0, 'h00,'h80,0));
      seen_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        #1;
        if (done || busy || addr_valid) seen_done = 1'b1;
      end
      check_bit("rst_no_done_after", seen_done, 1'b0);

      // Fresh 2x1 run after reset.
      @(negedge clk);
      start = 1'b1; n_in = 8'd2; n_out = 8'd1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("fresh_beat0", sample(), mk(1,1,0,1,0,0, 'h00,'h80,0));
      @(negedge clk);
      #1;
      check("fresh_beat1", sample(), mk(1,0,1,1,0,0, 'h01,'h80,1));
      got_done = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        #1;
        if (done) begin
          got_done = 1'b1;
          check_bit("fresh_done_latency", (k == 0), 1'b1);
          break;
        end
      end
      check_bit("fresh_done_seen", got_done, 1'b1);
      @(negedge clk);
      #1;
      check("fresh_after_done", sample(), mk(0,0,0,0,0,1, 'h80,'h00,2));
      pulse_reset();
      check("reset_clears_bank", sample(), mk(0,0,0,0,0,0, 'h00,'h80,0));
    end

    // Test 6: n_in=1, start pulsed in RUN and DONE is ignored.
    tab_b.push_back(mv(1,1,3,0, mk(0,0,0,0,0,0, 'h00,'h80,0)));
    tab_b.push_back(mv(1,5,7,0, mk(1,1,1,1,0,0, 'h00,'h80,0)));
    tab_b.push_back(mv(1,5,7,0, mk(1,1,1,1,0,0, 'h00,'h81,1)));
    tab_b.push_back(mv(0,1,3,0, mk(1,1,1,1,0,0, 'h00,'h82,2)));
    tab_b.push_back(mv(1,1,3,0, mk(0,0,0,0,1,0, 'h00,'h80,3)));
    tab_b.push_back(mv(0,1,3,0, mk(0,0,0,0,0,1, 'h80,'h00,3)));
    tab_b.push_back(mv(0,1,3,0, mk(0,0,0,0,0,1, 'h80,'h00,3)));
    run_table("tabB", tab_b);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
